dds_phase_accum: RTL and testbench

Phase generator at the head of the DDS datapath: a tunable phase accumulator that drives `sin_lookup`. Each enabled cycle it produces an 8-bit phase plus its quarter-wave decomposition (6-bit LUT address, mirror and negate flags). A 64-entry quarter-wave table downstream can then rebuild a full sine period. It also supports phase-coherent frequency updates through a valid/ready handshake, and an optional linear frequency sweep.

---
 rtl/dds_pkg.sv | 49 ++++
 rtl/dds_quad_decode.sv | 42 ++++
 rtl/dds_phase_accum.sv | 107 ++++++++++
 tb/tb_dds_phase_accum.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: phase/LUT widths, quadrant codes, tuning-word type
// and the quarter-wave mapping used by both the phase generator and sin_lookup.
// Pure declarations; no timing or flow control of its own.
package dds_pkg;

  localparam int PH_W   = 8;
  localparam int LUT_AW = 6;
  localparam int FTW_W  = 24;

  // Quadrant codes, taken from the two phase MSBs
  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [1:0] Q3 = 2'b11;

  typedef logic [FTW_W-1:0] ftw_t;

  typedef struct packed {
    logic [LUT_AW-1:0] addr;
    logic              mirror;
    logic              negate;
  } quad_t;

  // Fold a full-period phase onto the 64-entry quarter-wave table.
  // Quadrants 1 and 3 run the table backwards; quadrants 2 and 3 flip the sign.
  function automatic quad_t quad_map(input logic [PH_W-1:0] p);
    quad_t q;
    q.addr   = p[LUT_AW-1:0];
    q.mirror = 1'b0;
    q.negate = 1'b0;
    case (p[PH_W-1 -: 2])
      Q1: begin
        q.addr   = ~p[LUT_AW-1:0];
        q.mirror = 1'b1;
      end
      Q2: begin
        q.negate = 1'b1;
      end
      Q3: begin
        q.addr   = ~p[LUT_AW-1:0];
        q.mirror = 1'b1;
        q.negate = 1'b1;
      end
      default: ;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/dds_quad_decode.sv
// Offset add and quadrant decode of the accumulator phase, registered.
// Latency: one cycle from the phase input to the outputs.
// No backpressure: outputs load when en is high and hold otherwise.
module dds_quad_decode
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [PH_W-1:0]   acc_ph,
  input  logic [PH_W-1:0]   phase_off,
  output logic [PH_W-1:0]   phase_out,
  output logic [LUT_AW-1:0] lut_addr,
  output logic              mirror,
  output logic              negate
);

  logic [PH_W-1:0] p;
  quad_t           q;

  // Offset add wraps modulo 256; the carry is deliberately dropped
  always_comb begin
    p = acc_ph + phase_off;
    q = quad_map(p);
  end

  // Register the decoded sample only when a new accumulator value is present
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_out <= '0;
      lut_addr  <= '0;
      mirror    <= 1'b0;
      negate    <= 1'b0;
    end else if (en) begin
      phase_out <= p;
      lut_addr  <= q.addr;
      mirror    <= q.mirror;
      negate    <= q.negate;
    end
  end

endmodule

// File: rtl/dds_phase_accum.sv
// Tunable phase accumulator with shadowed tuning word, saturating sweep and quadrant decode.
// Latency: acc updates on the enable edge, decoded sample one cycle later (two from enable).
// ftw_valid/ftw_ready: one-deep shadow; ready drops after accept, returns after the apply edge.
module dds_phase_accum #(
  parameter int ACC_W  = 24,
  parameter int PH_W   = 8,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic [PH_W-1:0]   phase_off,
  input  logic              sweep_en,
  input  logic [STEP_W-1:0] sweep_step,
  output logic [PH_W-1:0]   phase_out,
  output logic [5:0]        lut_addr,
  output logic              mirror,
  output logic              negate,
  output logic              phase_valid,
  output logic              wrap
);

  import dds_pkg::*;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] ftw_shd;
  logic             shd_full;
  logic             en_q;
  logic             carry_q;

  logic [ACC_W:0]   acc_sum;
  logic             carry;
  logic [ACC_W:0]   sweep_sum;
  logic [ACC_W-1:0] ftw_swept;
  logic             apply;
  logic             xfer;

  assign ftw_ready = ~shd_full;

  // Next accumulator value, carry, saturating sweep and shadow apply/transfer decisions
  always_comb begin
    acc_sum   = {1'b0, acc} + {1'b0, ftw_act};
    carry     = enable & acc_sum[ACC_W];
    sweep_sum = {1'b0, ftw_act} + {{(ACC_W + 1 - STEP_W){1'b0}}, sweep_step};
    ftw_swept = sweep_sum[ACC_W] ? {ACC_W{1'b1}} : sweep_sum[ACC_W-1:0];
    // A pending word moves in at a period boundary, or at once while the accumulator is idle
    apply     = shd_full & (carry | ~enable);
    // Transfer and apply are mutually exclusive: one needs the shadow empty, the other full
    xfer      = ftw_valid & ~shd_full;
  end

  // Accumulator, active/shadow tuning words and their occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      ftw_act  <= '0;
      ftw_shd  <= '0;
      shd_full <= 1'b0;
    end else begin
      if (enable) begin
        acc <= acc_sum[ACC_W-1:0];
      end
      if (apply) begin
        ftw_act  <= ftw_shd;
        shd_full <= 1'b0;
      end else if (carry && sweep_en) begin
        ftw_act <= ftw_swept;
      end
      if (xfer) begin
        ftw_shd  <= ftw_in;
        shd_full <= 1'b1;
      end
    end
  end

  // Delay enable and carry so valid/wrap line up with the decoded sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      carry_q     <= 1'b0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      en_q        <= enable;
      carry_q     <= carry;
      phase_valid <= en_q;
      wrap        <= carry_q;
    end
  end

  dds_quad_decode u_decode (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_q),
    .acc_ph    (acc[ACC_W-1 -: PH_W]),
    .phase_off (phase_off),
    .phase_out (phase_out),
    .lut_addr  (lut_addr),
    .mirror    (mirror),
    .negate    (negate)
  );

endmodule

// File: tb/tb_dds_phase_accum.sv
// Scoreboard bench for dds_phase_accum: directed scenarios plus random traffic.
// Expected samples are computed from plain arithmetic on the phase/tuning state.
// A separate monitor pops and compares whenever phase_valid is high.
module tb_dds_phase_accum;
  import dds_pkg::*;

  localparam int     AW  = 24;
  localparam longint MOD = 64'd1 << AW;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        enable     = 1'b0;
  ftw_t        ftw_in     = '0;
  logic        ftw_valid  = 1'b0;
  logic [7:0]  phase_off  = '0;
  logic        sweep_en   = 1'b0;
  logic [15:0] sweep_step = '0;
  logic        ftw_ready;
  logic [7:0]  phase_out;
  logic [5:0]  lut_addr;
  logic        mirror, negate, phase_valid, wrap;

  dds_phase_accum dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ftw_in(ftw_in), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .phase_off(phase_off), .sweep_en(sweep_en), .sweep_step(sweep_step),
    .phase_out(phase_out), .lut_addr(lut_addr), .mirror(mirror), .negate(negate),
    .phase_valid(phase_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ph;
    logic [5:0] la;
    logic       mi;
    logic       ne;
    logic       wr;
  } exp_t;

  exp_t   sb[$];
  int     n_chk  = 0;
  int     n_fail = 0;

  // Reference state: accumulator, active and shadow tuning words
  longint acc_m = 0, act_m = 0, shd_m = 0;
  bit     full_m = 0;
  bit     pend = 0, pend_wrap = 0, accepted = 0;
  longint pend_acc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample expected from an accumulator value: top 8 bits plus offset, folded to a quarter wave
  function automatic exp_t ref_sample(input longint a, input int off, input bit w);
    exp_t e;
    int p, q, r;
    p = int'(((a >> (AW - 8)) + off) % 256);
    q = p / 64;
    r = p % 64;
    e.ph = 8'(p);
    e.la = 6'((q % 2 == 1) ? 63 - r : r);
    e.mi = (q % 2 == 1);
    e.ne = (q >= 2);
    e.wr = w;
    return e;
  endfunction

  // Advance the reference by one clock using the inputs as presented at that edge
  task automatic model_step();
    longint s;
    bit     carry, apply, full_old;
    accepted = 0;
    if (!rst_n) begin
      acc_m = 0; act_m = 0; shd_m = 0; full_m = 0; pend = 0;
      return;
    end
    if (pend) sb.push_back(ref_sample(pend_acc, int'(phase_off), pend_wrap));
    full_old = full_m;
    carry = 0;
    if (enable) begin
      s     = acc_m + act_m;
      carry = (s >= MOD);
      acc_m = s % MOD;
    end
    pend      = enable;
    pend_acc  = acc_m;
    pend_wrap = carry;
    apply = full_old && (carry || !enable);
    if (apply) begin
      act_m  = shd_m;
      full_m = 0;
    end else if (carry && sweep_en) begin
      act_m = act_m + longint'(sweep_step);
      if (act_m > MOD - 1) act_m = MOD - 1;
    end
    if (ftw_valid && !full_old) begin
      shd_m    = longint'(ftw_in);
      full_m   = 1;
      accepted = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ftw_ready", longint'(ftw_ready), longint'(!full_m));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input longint w);
    ftw_in    = ftw_t'(w);
    ftw_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: word 0x%0h not accepted, ftw_ready=%0b", w, ftw_ready);
    end
    ftw_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_phase_out",   longint'(phase_out),   0);
    chk("rst_lut_addr",    longint'(lut_addr),    0);
    chk("rst_mirror",      longint'(mirror),      0);
    chk("rst_negate",      longint'(negate),      0);
    chk("rst_phase_valid", longint'(phase_valid), 0);
    chk("rst_wrap",        longint'(wrap),        0);
    chk("rst_ftw_ready",   longint'(ftw_ready),   1);
  endtask

  // Monitor: every presented sample must match the oldest expectation, and none may go missing
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (phase_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_sample: phase_out=0x%0h with empty scoreboard", phase_out);
        end else begin
          e = sb.pop_front();
          chk("phase_out", longint'(phase_out), longint'(e.ph));
          chk("lut_addr",  longint'(lut_addr),  longint'(e.la));
          chk("mirror",    longint'(mirror),    longint'(e.mi));
          chk("negate",    longint'(negate),    longint'(e.ne));
          chk("wrap",      longint'(wrap),      longint'(e.wr));
        end
      end else begin
        n_chk++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL missing_sample: phase_valid=0 expected phase 0x%0h", sb[0].ph);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and steady run at step 1
    rst_n = 1'b0;
    run(2);
    chk_reset_state();
    rst_n = 1'b1;
    send(24'h010000);
    tick();
    enable = 1'b1;
    run(260);

    // Coherent update: second word waits for the wrap
    run(10);
    send(24'h020000);
    run(150);

    // Update while idle applies immediately
    enable = 1'b0;
    send(24'h040000);
    tick();
    chk("idle_apply_ready", longint'(ftw_ready), 1);
    enable = 1'b1;
    run(80);

    // Offset into quadrant 3 at step 1
    enable = 1'b0;
    send(24'h010000);
    tick();
    phase_off = 8'hC0;
    enable = 1'b1;
    run(270);

    // Sweep saturation
    enable = 1'b0;
    send(24'hFFFF00);
    tick();
    sweep_en   = 1'b1;
    sweep_step = 16'h0200;
    enable = 1'b1;
    run(12);
    chk("sweep_sat_ftw_act", longint'(dut.ftw_act), longint'(24'hFFFFFF));
    run(8);
    chk("sweep_hold_ftw_act", longint'(dut.ftw_act), longint'(24'hFFFFFF));
    sweep_en = 1'b0;

    // Mid-run reset discards a pending shadow word
    enable = 1'b0;
    rst_n  = 1'b0;
    tick();
    rst_n = 1'b1;
    send(24'h000100);
    tick();
    enable = 1'b1;
    run(3);
    send(24'h300000);
    chk("pending_ready_low", longint'(ftw_ready), 0);
    run(2);
    rst_n = 1'b0;
    tick();
    chk_reset_state();
    rst_n = 1'b1;
    run(40);
    chk("reset_discard_ftw_act", longint'(dut.ftw_act), 0);

    // Random traffic
    phase_off = 8'h00;
    for (int c = 0; c < 800; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) phase_off = 8'($urandom);
      if (!ftw_valid && $urandom_range(0, 15) == 0) begin
        ftw_valid = 1'b1;
        ftw_in    = ($urandom_range(0, 7) == 0) ? '0 : ftw_t'($urandom_range(0, 24'hFFFFFF));
      end
      sweep_en   = ($urandom_range(0, 3) == 0);
      sweep_step = 16'($urandom_range(0, 255));
      tick();
      if (accepted) ftw_valid = 1'b0;
    end

    // Drain
    ftw_valid = 1'b0;
    enable    = 1'b0;
    run(4);
    chk("scoreboard_drained", longint'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
